load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access initiator between the RV32I datapath and the word-organized data memory. Accepts one load or store request at a time (byte, halfword, word; signed/unsigned loads) and sequences it onto the memory's word-aligned A/WD/WE/RD port. It performs lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores. It sits at the core's MEM stage boundary; the memory itself stays word-only.

## Interface
Parameters:
- none (all widths fixed at 32-bit data/address)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- req  in  1  request strobe; accepted only when busy=0
- op_store  in  1  1=store, 0=load
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsigned_ld  in  1  zero-extend load (lbu/lhu); ignored for word and stores
- addr  in  32  byte address
- wdata  in  32  store data, low bits used for sub-word
- busy  out  1  request in flight
- done  out  1  one-cycle completion pulse
- rdata  out  32  load result, valid while done=1, held until next load completes
- misaligned  out  1  one-cycle error pulse, coincident with done
- mem_A  out  32  memory address, always {addr[31:2],2'b00}
- mem_WD  out  32  memory write word
- mem_WE  out  1  memory write enable, sampled by memory at posedge clk
- mem_RD  in  32  memory read word, combinationally valid for current mem_A

## Operation
- States: IDLE, LOAD, RDW, WRITE, DONE, ERR.
- IDLE: busy=0. On req=1, latch addr/size/op_store/unsigned_ld/wdata, then transition:
  - illegal size or misaligned access (half with addr[0]=1, word with addr[1:0]≠0): ERR
  - load: LOAD
  - word store: WRITE
  - byte/half store: RDW
- LOAD: drive mem_A; capture selected lane of mem_RD (byte = addr[1:0], half = addr[1]); sign- or zero-extend into rdata; → DONE.
- RDW: drive mem_A; capture mem_RD into merge register; → WRITE.
- WRITE: drive mem_A; mem_WD = merge register with target lane(s) replaced by wdata[7:0]/[15:0] (word store: wdata); mem_WE=1; → DONE.
- DONE: done=1 for one cycle; → IDLE.
- ERR: done=1 and misaligned=1 for one cycle; no memory access; rdata unchanged; → IDLE.
- Little-endian: byte k of the word = mem_RD[8k+7:8k].
- mem_WE is decoded from state only: exactly one pulse per store and none for loads.
- mem_A is 0 and mem_WD is 0 outside LOAD/RDW/WRITE.

## Timing
- Accept edge = edge E at which req=1 and state=IDLE.
- done asserts in the cycle after:
  - load: E+1 (done at E+2)
  - word store: E+1
  - sub-word store: E+2
  - error: E (done during the cycle following E)
- busy=1 from E until the edge that enters IDLE; req while busy is ignored (not queued).
- req in the DONE cycle is ignored; a back-to-back request is accepted on the next edge at the earliest.
- Reset values: state IDLE; busy, done, misaligned, mem_WE all 0; rdata, mem_A, mem_WD all 0x00000000; internal latches 0.
- Reset mid-operation: mem_WE drops immediately (asynchronously). No partial write occurs, and the interrupted request never signals done.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misalignment detection and the ERR state as above.
- LSU_MISALIGN_TRAP_EN undefined:
  - no ERR state; misaligned tied 0
  - half accesses use lane addr[1] and ignore addr[0]; word accesses ignore addr[1:0]
  - size=11 is treated as word
  - all accesses complete normally.

## Structure
- Package lsu_pkg:
  - size encodings (SZ_B, SZ_H, SZ_W)
  - state enum
  - lane-width constants
- Sub-module lsu_lane (combinational):
  - load path: extract + extend
  - store path: merge old word with new lane
- The FSM and registers stay in load_store_unit.

## Test plan
- Memory[0x100]=0x8899AABB; lw 0x100 → rdata=0x8899AABB, done at E+2, mem_WE never high.
- Same word:
  - lb 0x103 → 0xFFFFFF88
  - lbu 0x103 → 0x00000088
  - lh 0x102 → 0xFFFF8899
  - lhu 0x100 → 0x0000AABB
- sb 0x101, wdata=0x12345677 → one mem_WE pulse at E+2, memory word becomes 0x889977BB, done at E+3.
- sh 0x102, wdata=0x0000CAFE → memory 0xCAFEAABB; then sw 0x100, wdata=0xDEADBEEF → memory 0xDEADBEEF, done at E+2.
- lw 0x102:
  - with LSU_MISALIGN_TRAP_EN: done=misaligned=1 at E+1, no memory access, rdata unchanged
  - without it: rdata = word at 0x100.
- rst=0 during WRITE of sb → mem_WE falls immediately, memory unchanged, busy=0, no done. A req pulsed while busy=1 produces no second done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access-size encodings,
// FSM state enum, lane widths and the alignment check.
package lsu_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RDW,
        WRITE,
        DONE,
        ERR
    } lsu_state_e;

    // An illegal size code is reported the same way as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extracts and extends a load lane from the memory
// word, and merges a store lane into the previously read word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [1:0]        byte_off,
    input  logic [WORD_W-1:0] rd_word,
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] ld_data,
    output logic [WORD_W-1:0] st_word
);

    logic [BYTE_W-1:0] ld_byte;
    logic [HALF_W-1:0] ld_half;

    // NOTE: every output gets a full default before the case so no latch can be inferred.
    always_comb begin
        ld_byte = rd_word[{byte_off, 3'b000} +: BYTE_W];
        ld_half = byte_off[1] ? rd_word[WORD_W-1:HALF_W] : rd_word[HALF_W-1:0];
        ld_data = rd_word;
        case (size)
            SZ_B: ld_data = unsigned_ld ? {{(WORD_W-BYTE_W){1'b0}}, ld_byte}
                                        : {{(WORD_W-BYTE_W){ld_byte[BYTE_W-1]}}, ld_byte};
            SZ_H: ld_data = unsigned_ld ? {{(WORD_W-HALF_W){1'b0}}, ld_half}
                                        : {{(WORD_W-HALF_W){ld_half[HALF_W-1]}}, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        st_word = old_word;
        case (size)
            SZ_B: st_word[{byte_off, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
            SZ_H: begin
                if (byte_off[1]) st_word[WORD_W-1:HALF_W] = wdata[HALF_W-1:0];
                else             st_word[HALF_W-1:0]      = wdata[HALF_W-1:0];
            end
            default: st_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the datapath and a word-only memory port.
// Define LSU_MISALIGN_TRAP_EN to enable misalignment/illegal-size trapping (ERR state).
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        op_store,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        op_store_q, op_store_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;

    logic        trap;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    lsu_lane u_lane (
        .size        (size_q),
        .unsigned_ld (unsigned_q),
        .byte_off    (addr_q[1:0]),
        .rd_word     (mem_RD),
        .old_word    (merge_q),
        .wdata       (wdata_q),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_misaligned(size, addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        op_store_d = op_store_q;
        unsigned_d = unsigned_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d     = addr;
                    size_d     = (size == SZ_X) ? SZ_W : size;
                    op_store_d = op_store;
                    unsigned_d = unsigned_ld;
                    wdata_d    = wdata;
                    if (trap)                             state_d = ERR;
                    else if (!op_store)                   state_d = LOAD;
                    else if (size == SZ_B || size == SZ_H) state_d = RDW;
                    else                                  state_d = WRITE;
                end
            end
            LOAD: begin
                rdata_d = ld_data;
                state_d = DONE;
            end
            RDW: begin
                merge_d = mem_RD;
                state_d = WRITE;
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the async reset clears every register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            op_store_q <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            merge_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            op_store_q <= op_store_d;
            unsigned_q <= unsigned_d;
            wdata_q    <= wdata_d;
            merge_q    <= merge_d;
            rdata_q    <= rdata_d;
        end
    end

    // Memory strobes decode from state alone, so a reset removes mem_WE at once.
    always_comb begin
        mem_A  = '0;
        mem_WD = '0;
        mem_WE = 1'b0;
        case (state_q)
            LOAD, RDW: mem_A = {addr_q[31:2], 2'b00};
            WRITE: begin
                mem_A  = {addr_q[31:2], 2'b00};
                mem_WD = st_word;
                mem_WE = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE) || (state_q == ERR);
    assign rdata = rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = (state_q == ERR);
`else
    assign misaligned = 1'b0;
`endif

    // op_store is fully encoded in the state path; the latched copy is kept for visibility.
    logic unused_ok;
    assign unused_ok = op_store_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a one-word memory model at 0x100.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        op_store = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        unsigned_ld = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, misaligned, mem_WE;
    logic [31:0] rdata, mem_A, mem_WD, mem_RD;

    logic [31:0] mem_word;
    logic        poke = 1'b0;
    logic [31:0] poke_val = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .op_store    (op_store),
        .size        (size),
        .unsigned_ld (unsigned_ld),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .misaligned  (misaligned),
        .mem_A       (mem_A),
        .mem_WD      (mem_WD),
        .mem_WE      (mem_WE),
        .mem_RD      (mem_RD)
    );

    assign mem_RD = (mem_A == 32'h100) ? mem_word : 32'h0;

    always @(posedge clk) begin
        if (poke)                             mem_word <= poke_val;
        else if (mem_WE && mem_A == 32'h100)  mem_word <= mem_WD;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preset(input logic [31:0] v);
        @(negedge clk);
        poke = 1'b1;
        poke_val = v;
        @(negedge clk);
        poke = 1'b0;
    endtask

    // done_at/we_at are edge indices relative to the accept edge E (done high before edge E+n).
    task automatic run_op(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int done_at, output int we_cnt, output int we_at,
                          output logic mis, output logic [31:0] rd,
                          output logic [31:0] a0, output logic b0);
        @(negedge clk);
        req = 1'b1; op_store = st; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        done_at = 0; we_cnt = 0; we_at = 0; mis = 1'b0; rd = '0;
        a0 = mem_A;
        b0 = busy;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (mem_WE) begin
                we_cnt++;
                we_at = k + 1;
            end
            if (done) begin
                done_at = k + 1;
                mis = misaligned;
                rd = rdata;
                break;
            end
        end
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] exp_rd,
                           input int exp_done, input logic exp_mis);
        int d, wc, wa;
        logic m, b0;
        logic [31:0] rd, a0;
        run_op(1'b0, sz, uns, a, 32'h0, d, wc, wa, m, rd, a0, b0);
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".done_at"}, 32'(d), 32'(exp_done));
        check({tag, ".misaligned"}, 32'(m), 32'(exp_mis));
        check({tag, ".we_count"}, 32'(wc), 32'd0);
        check({tag, ".mem_A"}, a0, exp_mis ? 32'h0 : {a[31:2], 2'b00});
        check({tag, ".busy"}, 32'(b0), 32'd1);
    endtask

    task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_mem,
                            input int exp_done, input int exp_we_at);
        int d, wc, wa;
        logic m, b0;
        logic [31:0] rd, a0;
        run_op(1'b1, sz, 1'b0, a, wd, d, wc, wa, m, rd, a0, b0);
        check({tag, ".done_at"}, 32'(d), 32'(exp_done));
        check({tag, ".we_count"}, 32'(wc), 32'd1);
        check({tag, ".we_at"}, 32'(wa), 32'(exp_we_at));
        check({tag, ".misaligned"}, 32'(m), 32'd0);
        check({tag, ".memory"}, mem_word, exp_mem);
    endtask

    initial begin
        int n_done;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.misaligned", 32'(misaligned), 32'd0);
        check("reset.mem_WE", 32'(mem_WE), 32'd0);
        check("reset.rdata", rdata, 32'h0);
        check("reset.mem_A", mem_A, 32'h0);
        check("reset.mem_WD", mem_WD, 32'h0);
        rst = 1'b1;

        preset(32'h8899AABB);
        do_load("lw_100",  2'b10, 1'b0, 32'h100, 32'h8899AABB, 2, 1'b0);
        do_load("lb_103",  2'b00, 1'b0, 32'h103, 32'hFFFFFF88, 2, 1'b0);
        do_load("lbu_103", 2'b00, 1'b1, 32'h103, 32'h00000088, 2, 1'b0);
        do_load("lb_100",  2'b00, 1'b0, 32'h100, 32'hFFFFFFBB, 2, 1'b0);
        do_load("lh_102",  2'b01, 1'b0, 32'h102, 32'hFFFF8899, 2, 1'b0);
        do_load("lhu_100", 2'b01, 1'b1, 32'h100, 32'h0000AABB, 2, 1'b0);

        do_store("sb_101", 2'b00, 32'h101, 32'h12345677, 32'h889977BB, 3, 2);
        preset(32'h8899AABB);
        do_store("sh_102", 2'b01, 32'h102, 32'h0000CAFE, 32'hCAFEAABB, 3, 2);
        do_store("sw_100", 2'b10, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 2, 1);

`ifdef LSU_MISALIGN_TRAP_EN
        do_load("lw_102", 2'b10, 1'b0, 32'h102, 32'h0000AABB, 1, 1'b1);
`else
        do_load("lw_102", 2'b10, 1'b0, 32'h102, 32'hDEADBEEF, 2, 1'b0);
`endif
        do_load("lbu_101", 2'b00, 1'b1, 32'h101, 32'h000000BE, 2, 1'b0);
        do_load("lh_100",  2'b01, 1'b0, 32'h100, 32'hFFFFBEEF, 2, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        do_load("lsz3_100", 2'b11, 1'b0, 32'h100, 32'hFFFFBEEF, 1, 1'b1);
`else
        do_load("lsz3_100", 2'b11, 1'b0, 32'h100, 32'hDEADBEEF, 2, 1'b0);
`endif
        check("after_loads.memory", mem_word, 32'hDEADBEEF);

        // Reset asserted while a byte store sits in WRITE.
        @(negedge clk);
        req = 1'b1; op_store = 1'b1; size = 2'b00; unsigned_ld = 1'b0;
        addr = 32'h101; wdata = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rst_mid.we_before", 32'(mem_WE), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rst_mid.we_after", 32'(mem_WE), 32'd0);
        check("rst_mid.busy", 32'(busy), 32'd0);
        n_done = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rst_mid.no_done", 32'(n_done), 32'd0);
        check("rst_mid.memory", mem_word, 32'hDEADBEEF);

        // req held high through the LOAD and DONE cycles must not start a second access.
        @(negedge clk);
        req = 1'b1; op_store = 1'b0; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (done) n_done++;
            if (k == 1) req = 1'b0;
        end
        check("busy_req.done_count", 32'(n_done), 32'd1);
        check("busy_req.rdata", rdata, 32'hDEADBEEF);
        check("busy_req.idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
